// File: rtl/vidtiming.sv
// Programmable video timing generator: pixel position, syncs and frame/line markers
// with validated, frame-boundary-deferred reconfiguration.
module vidtiming #(
  parameter int W      = 16,
  parameter int HACT   = 1280,
  parameter int HFRONT = 72,
  parameter int HSYNC  = 80,
  parameter int HBACK  = 216,
  parameter int VACT   = 720,
  parameter int VFRONT = 3,
  parameter int VSYNC  = 5,
  parameter int VBACK  = 22,
  parameter int HSPOL  = 1,
  parameter int VSPOL  = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] cfg_hact,
  input  logic [W-1:0] cfg_hfront,
  input  logic [W-1:0] cfg_hsync,
  input  logic [W-1:0] cfg_hback,
  input  logic [W-1:0] cfg_vact,
  input  logic [W-1:0] cfg_vfront,
  input  logic [W-1:0] cfg_vsync,
  input  logic [W-1:0] cfg_vback,
  input  logic         cfg_hspol,
  input  logic         cfg_vspol,
  input  logic         cfg_load,
  output logic         cfg_pending,
  output logic         cfg_err,
  output logic         de,
  output logic         hs,
  output logic         vs,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         sof,
  output logic         eol
);

  localparam int D = W + 2;

  typedef struct packed {
    logic [W-1:0] hact;
    logic [W-1:0] hfront;
    logic [W-1:0] hsync;
    logic [W-1:0] hback;
    logic [W-1:0] vact;
    logic [W-1:0] vfront;
    logic [W-1:0] vsync;
    logic [W-1:0] vback;
    logic         hspol;
    logic         vspol;
  } tcfg_t;

  localparam logic  HSP     = 1'(HSPOL);
  localparam logic  VSP     = 1'(VSPOL);
  localparam tcfg_t RST_CFG = {W'(HACT), W'(HFRONT), W'(HSYNC), W'(HBACK),
                               W'(VACT), W'(VFRONT), W'(VSYNC), W'(VBACK), HSP, VSP};
  localparam logic [D-1:0] LIM = {2'b01, {W{1'b0}}};

  function automatic logic [D-1:0] ext(input logic [W-1:0] v);
    return {2'b00, v};
  endfunction

  tcfg_t        act, pend, ld;
  logic [W-1:0] cx, cy, cx_n, cy_n;
  logic         run_r;
  logic [D-1:0] hson, hsoff, htot, vson, vsoff, vtot, ld_htot, ld_vtot;
  logic         ld_ok, h_last, v_last, wrap, apply;
  logic         de_d, hs_raw, vs_raw;

  assign ld = {cfg_hact, cfg_hfront, cfg_hsync, cfg_hback,
               cfg_vact, cfg_vfront, cfg_vsync, cfg_vback, cfg_hspol, cfg_vspol};

  assign hson  = ext(act.hact) + ext(act.hfront);
  assign hsoff = hson + ext(act.hsync);
  assign htot  = hsoff + ext(act.hback);
  assign vson  = ext(act.vact) + ext(act.vfront);
  assign vsoff = vson + ext(act.vsync);
  assign vtot  = vsoff + ext(act.vback);

  assign ld_htot = ext(ld.hact) + ext(ld.hfront) + ext(ld.hsync) + ext(ld.hback);
  assign ld_vtot = ext(ld.vact) + ext(ld.vfront) + ext(ld.vsync) + ext(ld.vback);
  assign ld_ok   = (|ld.hact) && (|ld.hfront) && (|ld.hsync) && (|ld.hback) &&
                   (|ld.vact) && (|ld.vfront) && (|ld.vsync) && (|ld.vback) &&
                   (ld_htot <= LIM) && (ld_vtot <= LIM);

  // run_r marks that en was already high last edge, so counting starts one cycle after enable
  assign h_last = (ext(cx) == htot - D'(1));
  assign v_last = (ext(cy) == vtot - D'(1));
  assign wrap   = en && run_r && h_last && v_last;
  assign apply  = cfg_pending && (wrap || !en);

  // Next pixel position
  always_comb begin
    cx_n = cx;
    cy_n = cy;
    if (!en) begin
      cx_n = '0;
      cy_n = '0;
    end else if (run_r) begin
      if (h_last) begin
        cx_n = '0;
        if (v_last) begin
          cy_n = '0;
        end else begin
          cy_n = cy + W'(1);
        end
      end else begin
        cx_n = cx + W'(1);
      end
    end else begin
      cx_n = cx;
      cy_n = cy;
    end
  end

  // Raster decode of the current position; raw syncs are forced inactive while idle
  always_comb begin
    de_d   = run_r && (ext(cx) < ext(act.hact)) && (ext(cy) < ext(act.vact));
    hs_raw = run_r && (ext(cx) >= hson) && (ext(cx) < hsoff);
    vs_raw = run_r && (ext(cy) >= vson) && (ext(cy) < vsoff);
  end

  // Configuration registers, validation result and pending flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      act         <= RST_CFG;
      pend        <= '0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (apply) act <= pend;
      if (cfg_load && ld_ok) pend <= ld;
      cfg_pending <= (cfg_pending && !apply) || (cfg_load && ld_ok);
      cfg_err     <= cfg_load && !ld_ok;
    end
  end

  // Counters and the aligned output register stage
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cx    <= '0;
      cy    <= '0;
      run_r <= 1'b0;
      de    <= 1'b0;
      hs    <= ~HSP;
      vs    <= ~VSP;
      x     <= '0;
      y     <= '0;
      sof   <= 1'b0;
      eol   <= 1'b0;
    end else begin
      cx    <= cx_n;
      cy    <= cy_n;
      run_r <= en;
      de    <= de_d;
      hs    <= ~(hs_raw ^ act.hspol);
      vs    <= ~(vs_raw ^ act.vspol);
      x     <= run_r ? cx : '0;
      y     <= run_r ? cy : '0;
      sof   <= run_r && (cx == '0) && (cy == '0);
      eol   <= run_r && h_last;
    end
  end

endmodule

// File: tb/tb_vidtiming.sv
// Scoreboard bench for vidtiming: a pixel-index reference model predicts every output
// cycle; a monitor pops the predictions and compares them with the DUT.
module tb_vidtiming;

  localparam int W = 16;

  typedef struct {
    int hact, hfront, hsync, hback, vact, vfront, vsync, vback;
    bit hspol, vspol;
  } cfg_t;

  typedef struct {
    bit de, hs, vs, sof, eol, pend, err;
    int x, y;
  } exp_t;

  logic clk = 1'b0;
  logic rstn, en, cfg_load;
  cfg_t ldc;
  logic cfg_pending, cfg_err, de, hs, vs, sof, eol;
  logic [W-1:0] x, y;

  vidtiming #(.W(16), .HACT(8), .HFRONT(2), .HSYNC(3), .HBACK(3),
              .VACT(4), .VFRONT(1), .VSYNC(2), .VBACK(1), .HSPOL(1), .VSPOL(1)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .cfg_hact(ldc.hact[W-1:0]), .cfg_hfront(ldc.hfront[W-1:0]),
    .cfg_hsync(ldc.hsync[W-1:0]), .cfg_hback(ldc.hback[W-1:0]),
    .cfg_vact(ldc.vact[W-1:0]), .cfg_vfront(ldc.vfront[W-1:0]),
    .cfg_vsync(ldc.vsync[W-1:0]), .cfg_vback(ldc.vback[W-1:0]),
    .cfg_hspol(ldc.hspol), .cfg_vspol(ldc.vspol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .de(de), .hs(hs), .vs(vs),
    .x(x), .y(y), .sof(sof), .eol(eol));

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t expq[$];

  // reference model state: a linear pixel index into the active frame
  cfg_t act_m, pend_m;
  bit   pflag_m, run_m;
  int   p_m;

  function automatic cfg_t mk(int ha, int hf, int hsy, int hb, int va, int vf, int vsy, int vb,
                              bit hp, bit vp);
    cfg_t c;
    c.hact = ha; c.hfront = hf; c.hsync = hsy; c.hback = hb;
    c.vact = va; c.vfront = vf; c.vsync = vsy; c.vback = vb;
    c.hspol = hp; c.vspol = vp;
    return c;
  endfunction

  function automatic int htot(cfg_t c);
    return c.hact + c.hfront + c.hsync + c.hback;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.vact + c.vfront + c.vsync + c.vback;
  endfunction

  function automatic bit valid(cfg_t c);
    return c.hact > 0 && c.hfront > 0 && c.hsync > 0 && c.hback > 0 &&
           c.vact > 0 && c.vfront > 0 && c.vsync > 0 && c.vback > 0 &&
           htot(c) <= 65536 && vtot(c) <= 65536;
  endfunction

  function automatic exp_t idle_out(cfg_t c);
    exp_t e;
    e = '{default: 0};
    e.hs = !c.hspol;
    e.vs = !c.vspol;
    return e;
  endfunction

  function automatic exp_t pixel_out(cfg_t c, int p);
    exp_t e;
    int px, py, hs0, vs0;
    e = '{default: 0};
    px = p % htot(c);
    py = p / htot(c);
    hs0 = c.hact + c.hfront;
    vs0 = c.vact + c.vfront;
    e.x = px; e.y = py;
    e.de  = (px < c.hact) && (py < c.vact);
    e.hs  = ((px >= hs0) && (px < hs0 + c.hsync)) == c.hspol;
    e.vs  = ((py >= vs0) && (py < vs0 + c.vsync)) == c.vspol;
    e.sof = (p == 0);
    e.eol = (px == htot(c) - 1);
    return e;
  endfunction

  task automatic model_step();
    exp_t e;
    bit ok, wrap, apply;
    if (!rstn) begin
      act_m = mk(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
      pflag_m = 1'b0; p_m = 0; run_m = 1'b0;
      e = idle_out(act_m);
    end else begin
      ok = valid(ldc);
      e = run_m ? pixel_out(act_m, p_m) : idle_out(act_m);
      e.err = cfg_load && !ok;
      wrap  = run_m && en && (p_m == htot(act_m) * vtot(act_m) - 1);
      apply = pflag_m && (wrap || !en);
      if (!en || !run_m) p_m = 0;
      else p_m = (p_m + 1) % (htot(act_m) * vtot(act_m));
      if (apply) act_m = pend_m;
      if (cfg_load && ok) begin
        pend_m = ldc; pflag_m = 1'b1;
      end else if (apply) begin
        pflag_m = 1'b0;
      end
      run_m = en;
      e.pend = pflag_m;
    end
    expq.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // monitor: one prediction per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        vectors++;
        chk("de", 32'(de), 32'(e.de));
        chk("hs", 32'(hs), 32'(e.hs));
        chk("vs", 32'(vs), 32'(e.vs));
        chk("sof", 32'(sof), 32'(e.sof));
        chk("eol", 32'(eol), 32'(e.eol));
        chk("x", 32'(x), e.x);
        chk("y", 32'(y), e.y);
        chk("cfg_pending", 32'(cfg_pending), 32'(e.pend));
        chk("cfg_err", 32'(cfg_err), 32'(e.err));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(cfg_t c);
    ldc = c;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // wait until the next edge will see pixel index target in a running frame
  task automatic wait_pos(int target);
    int n = 0;
    while (!(run_m && en && p_m == target) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      miscompares++;
      $display("FAIL wait_pos timeout: reached %0d, expected %0d", p_m, target);
    end
  endtask

  function automatic cfg_t rnd_cfg();
    return mk($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5),
              $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5),
              $urandom_range(1, 5), $urandom_range(1, 5),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  initial begin
    cfg_t c;
    rstn = 1'b0; en = 1'b0; cfg_load = 1'b0;
    ldc = mk(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
    cyc(3);
    rstn = 1'b1;
    cyc(2);
    en = 1'b1;
    cyc(300);
    // polarity flip requested mid-frame
    wait_pos(37);
    load(mk(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0));
    cyc(300);
    // deferred horizontal shrink at x=3, y=1
    wait_pos(19);
    load(mk(4, 1, 1, 2, 4, 1, 2, 1, 1'b1, 1'b1));
    cyc(200);
    // rejections: zero field, then total beyond 2^W; the exact 2^W boundary is accepted
    wait_pos(5);
    load(mk(4, 1, 0, 2, 4, 1, 2, 1, 1'b1, 1'b1));
    cyc(3);
    load(mk(65535, 2, 1, 1, 4, 1, 2, 1, 1'b1, 1'b1));
    cyc(3);
    load(mk(4, 1, 1, 2, 65533, 1, 1, 2, 1'b1, 1'b1));
    cyc(3);
    wait_pos(10);
    load(mk(65533, 1, 1, 1, 4, 1, 2, 1, 1'b1, 1'b1));
    load(mk(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1));
    cyc(100);
    // collision: B lands exactly on the frame wrap while A is pending
    wait_pos(3);
    load(mk(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b1));
    wait_pos(htot(act_m) * vtot(act_m) - 1);
    load(mk(6, 1, 1, 2, 3, 1, 1, 1, 1'b1, 1'b0));
    cyc(250);
    // mid-frame reset with a load pending
    wait_pos(5);
    load(mk(5, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0));
    wait_pos(2 * htot(act_m) + 5);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    cyc(40);
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(150);
    // randomized mix of loads, enable drops and resets
    for (int i = 0; i < 4000; i++) begin
      en   = ($urandom_range(0, 99) < 97);
      rstn = ($urandom_range(0, 999) >= 3);
      if ($urandom_range(0, 99) < 4) begin
        c = rnd_cfg();
        case ($urandom_range(0, 9))
          0: c.hsync = 0;
          1: c.vback = 0;
          2: c.hact = 0;
          default: c.hact = c.hact;
        endcase
        ldc = c;
        cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      @(negedge clk);
    end
    rstn = 1'b1; en = 1'b1; cfg_load = 1'b0;
    cyc(5);
    if (expq.size() > 1) begin
      miscompares++;
      $display("FAIL scoreboard backlog: got %0d entries, expected at most 1", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vidtiming.md
# vidtiming

Programmable video timing generator that produces the pixel-position and sync stream for the HDMI transmitter's parallel video input. It is the parametrised successor to the fixed 1280x720 raster counter in the HDMI controller, with the following additions:
- Counter width is a parameter and the reset timings come from parameters.
- Timings and sync polarities can be reloaded at runtime and take effect only on a frame boundary.
- Configurations are validated before they are accepted.
- Outputs are registered and carry frame and line markers.

## Interface
Parameters:
- W, 16: width of x/y counters and all timing fields.
- HACT, 1280; HFRONT, 72; HSYNC, 80; HBACK, 216: reset horizontal timing, in pixels.
- VACT, 720; VFRONT, 3; VSYNC, 5; VBACK, 22: reset vertical timing, in lines.
- HSPOL, 1; VSPOL, 1: reset sync polarity (1 = active-high).

Ports:
- clk  in  1  pixel clock; the only clock.
- rstn  in  1  synchronous, active-low reset.
- en  in  1  run enable.
- cfg_hact, cfg_hfront, cfg_hsync, cfg_hback  in  W each  new horizontal timing.
- cfg_vact, cfg_vfront, cfg_vsync, cfg_vback  in  W each  new vertical timing.
- cfg_hspol, cfg_vspol  in  1 each  new sync polarity.
- cfg_load  in  1  one-cycle strobe that captures all cfg_* inputs.
- cfg_pending  out  1  a valid configuration is waiting to be applied.
- cfg_err  out  1  one-cycle pulse: the last load was rejected.
- de  out  1  active video.
- hs, vs  out  1 each  syncs, polarity applied.
- x, y  out  W each  current pixel position.
- sof  out  1  first pixel of frame (x=0, y=0).
- eol  out  1  last pixel of a line.

## Operation
- Configuration is held in two register sets:
  - The active set drives the counters.
  - The pending set holds a validated load that has not yet been applied.
- Derived values, all computed in W+2 bits:
  - HSON = hact+hfront, HSOFF = HSON+hsync, HTOT = HSOFF+hback.
  - Vertical values are derived the same way.
- Validation on cfg_load:
  - The load is rejected if any timing field is 0, or if HTOT or VTOT exceeds 2^W.
  - On rejection: cfg_err pulses for one cycle and the pending set and cfg_pending are unchanged.
  - Otherwise the pending set is overwritten and cfg_pending is set. Back-to-back loads: the last one wins.
- Apply: the pending set is copied to active and cfg_pending clears in a cycle where cfg_pending=1 and either:
  - the counters wrap at end of frame (cx=HTOT-1, cy=VTOT-1, en=1), or
  - en=0.
- Load and apply in the same cycle: the earlier pending content is applied; the new load is validated into the pending set and cfg_pending stays 1.
- Internal counters cx, cy:
  - With en=1: cx increments; at HTOT-1 it wraps to 0 and cy increments; cy wraps to 0 at VTOT-1.
  - With en=0: cx and cy are forced to 0.
- Decode of (cx, cy):
  - de = cx<hact && cy<vact (the vertical term uses vact).
  - hs raw = HSON<=cx<HSOFF; vs raw = VSON<=cy<VSOFF. vs changes only when cx=0.
  - Output sync level = raw XNOR pol, so pol=0 gives an active-low output.
  - sof = (cx=0 && cy=0); eol = (cx=HTOT-1).
- Output register:
  - All decoded signals plus x=cx and y=cy pass through one register stage, so every output is mutually aligned.
  - While en=0 the registered outputs are: de=0, sof=0, eol=0, x=0, y=0, and hs/vs at their inactive level.

## Timing
- Reset (rstn=0 sampled at an edge):
  - Active set returns to the parameter values; pending set and cfg_pending are cleared.
  - cx=cy=0; cfg_err=0, de=0, sof=0, eol=0, x=0, y=0.
  - hs = ~HSPOL and vs = ~VSPOL.
- Reset asserted mid-frame or mid-load takes priority over everything, including a cfg_load in the same cycle.
- Latency: en first sampled high at edge T:
  - The output register shows x=0, y=0, sof=1, de=1 after edge T+1.
  - Each pixel then takes exactly one clock.
- en falling, first sampled low at edge T: outputs are inactive after edge T+1. Re-enabling restarts the frame at (0,0).
- cfg_err is asserted in the cycle after the rejected cfg_load, for one cycle.
- After a frame-wrap apply, the first sof of the next frame already uses the new timing.

## Test plan
- Reset and idle, with W=16, HACT=8, HFRONT=2, HSYNC=3, HBACK=3, VACT=4, VFRONT=1, VSYNC=2, VBACK=1:
  - Stimulus: release reset, then set en=1.
  - Required: sof at output cycle 1; sof repeats every 128 cycles.
  - Required: de high 8 of every 16 cycles, only for y<4; hs high for x=10..12; vs high for y=5..6; eol at x=15.
- Polarity, same parameters:
  - Stimulus: cfg_load with hspol=0, vspol=0 in mid-frame.
  - Required: cfg_pending=1 until the wrap; next frame hs is low for x=10..12 and high otherwise.
- Deferred apply:
  - Stimulus: load hact=4, hfront=1, hsync=1, hback=2 at x=3, y=1.
  - Required: the current frame keeps HTOT=16; after the wrap HTOT=8 and de is high for x=0..3.
- Rejection:
  - Stimulus: load with hsync=0; then, with W=8, load with HTOT=300.
  - Required: cfg_err pulses once per load; cfg_pending and timing are unchanged.
- Collision:
  - Stimulus: a valid load A is pending; load B is asserted exactly on the end-of-frame cycle.
  - Required: frame N+1 uses A; cfg_pending stays 1; frame N+2 uses B.
- Mid-frame reset and en drop:
  - Stimulus: rstn=0 at x=5, y=2 with a load pending.
  - Required: next cycle x=y=0, de=0, cfg_pending=0, and parameter timings are restored.
  - Stimulus: en=0 for 3 cycles, then en=1.
  - Required: restart at sof.
